// File: rtl/led_pkg.sv
// Shared definitions for the seven-segment scroll controller.
//   state_e      : controller FSM states (IDLE / RUN / PAUSED)
//   DIGIT_W      : bits per hex digit
//   BLANK_NIBBLE : nibble driven on a digit whose blank bit is set
package led_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BLANK_NIBBLE = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/led_window_mux.sv
// Combinational window extractor for the scrolling display.
// The message sits on a virtual tape of period P = len + WIN_DIGITS whose
// first WIN_DIGITS cells are blank; cell WIN_DIGITS+k holds message digit k
// (k = 0 is the most significant nibble). Digit i of the window (i = 0 is
// the leftmost) shows tape cell (pos + i) mod P.
// Ports:
//   msg_i       : stored message, digits in msg_i[DIGIT_W*len-1:0]
//   len_i       : message length in digits (already clamped to MSG_DIGITS)
//   pos_i       : current scroll position, always < P
//   win_data_o  : window nibbles, leftmost in the top nibble
//   win_blank_o : 1 = digit off, bit WIN_DIGITS-1 is the leftmost digit
module led_window_mux import led_pkg::*; #(
  parameter int  MSG_DIGITS = 16,
  parameter int  WIN_DIGITS = 8,
  localparam int LEN_W      = $clog2(MSG_DIGITS + 1),
  localparam int POS_W      = $clog2(MSG_DIGITS + WIN_DIGITS)
) (
  input  logic [DIGIT_W*MSG_DIGITS-1:0] msg_i,
  input  logic [LEN_W-1:0]              len_i,
  input  logic [POS_W-1:0]              pos_i,
  output logic [DIGIT_W*WIN_DIGITS-1:0] win_data_o,
  output logic [WIN_DIGITS-1:0]         win_blank_o
);

  int period;
  int idx;
  int sh;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves one unassigned, which would infer a latch.
    period      = int'(len_i) + WIN_DIGITS;
    idx         = 0;
    sh          = 0;
    win_data_o  = '0;
    win_blank_o = '0;
    for (int i = 0; i < WIN_DIGITS; i++) begin
      // pos < P and i < WIN_DIGITS <= P, so pos + i < 2P: one subtract wraps it.
      idx = int'(pos_i) + i;
      if (idx >= period) idx = idx - period;
      if (idx < WIN_DIGITS) begin
        win_blank_o[WIN_DIGITS-1-i]                   = 1'b1;
        win_data_o[DIGIT_W*(WIN_DIGITS-1-i) +: DIGIT_W] = BLANK_NIBBLE;
      end else begin
        // Digit k = idx - WIN_DIGITS lives at nibble (len - 1 - k).
        sh = int'(len_i) - 1 - (idx - WIN_DIGITS);
        win_data_o[DIGIT_W*(WIN_DIGITS-1-i) +: DIGIT_W] = msg_i[DIGIT_W*sh +: DIGIT_W];
      end
    end
  end

endmodule

// File: rtl/led_scroll_ctrl.sv
// Scroll sequencer for the 8-digit seven-segment multiplexer.
// Accepts a hex message over a valid/ready handshake, then steps a
// WIN_DIGITS-wide window across it every STEP_CYCLES clocks.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   load_valid/load_ready : message handshake; load_ready is high in IDLE and PAUSED
//   load_data, load_len   : message digits and length (length clamped to MSG_DIGITS)
//   dir                   : 0 = text moves left, 1 = text moves right (sampled at step)
//   pause                 : freezes position and step counter while high
//   stop                  : abort to IDLE with a blank display
//   disp_data, disp_blank : registered window and per-digit blank mask
//   busy                  : controller not in IDLE
//   wrap_pulse            : one-cycle pulse after a step that wraps the position
module led_scroll_ctrl import led_pkg::*; #(
  parameter int  MSG_DIGITS  = 16,
  parameter int  WIN_DIGITS  = 8,
  parameter int  STEP_CYCLES = 50000000,
  localparam int LEN_W       = $clog2(MSG_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [DIGIT_W*MSG_DIGITS-1:0] load_data,
  input  logic [LEN_W-1:0]              load_len,
  input  logic                          dir,
  input  logic                          pause,
  input  logic                          stop,
  output logic [DIGIT_W*WIN_DIGITS-1:0] disp_data,
  output logic [WIN_DIGITS-1:0]         disp_blank,
  output logic                          busy,
  output logic                          wrap_pulse
);

  localparam int POS_W = $clog2(MSG_DIGITS + WIN_DIGITS);
  localparam int PER_W = POS_W + 1;
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  state_e                          state_q;
  logic [POS_W-1:0]                pos_q, pos_d, pos_step;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [DIGIT_W*MSG_DIGITS-1:0]   msg_q;
  logic [LEN_W-1:0]                len_q, len_clamp;
  logic [DIGIT_W*WIN_DIGITS-1:0]   disp_data_q, win_data;
  logic [WIN_DIGITS-1:0]           disp_blank_q, win_blank;
  logic                            wrap_q, wrap_d;
  logic                            step_now, pos_wrap;
  logic [PER_W-1:0]                period, last_pos;

  led_window_mux #(
    .MSG_DIGITS (MSG_DIGITS),
    .WIN_DIGITS (WIN_DIGITS)
  ) u_window_mux (
    .msg_i       (msg_q),
    .len_i       (len_q),
    .pos_i       (pos_q),
    .win_data_o  (win_data),
    .win_blank_o (win_blank)
  );

  // One counting/stepping cycle; applied in RUN and on the PAUSED->RUN resume cycle.
  always_comb begin
    period    = PER_W'(len_q) + PER_W'(WIN_DIGITS);
    last_pos  = period - PER_W'(1);
    step_now  = (cnt_q == CNT_W'(STEP_CYCLES - 1));
    pos_wrap  = dir ? (pos_q == '0) : ({1'b0, pos_q} == last_pos);
    if (dir) pos_step = pos_wrap ? last_pos[POS_W-1:0] : pos_q - POS_W'(1);
    else     pos_step = pos_wrap ? '0 : pos_q + POS_W'(1);
    cnt_d     = step_now ? '0 : cnt_q + CNT_W'(1);
    pos_d     = step_now ? pos_step : pos_q;
    wrap_d    = step_now && pos_wrap;
    len_clamp = (load_len > LEN_W'(MSG_DIGITS)) ? LEN_W'(MSG_DIGITS) : load_len;
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge values of the others, independent of code order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      cnt_q        <= '0;
      // NOTE: the message store is a plain register, not a RAM, so it can
      // and does take a defined reset value.
      msg_q        <= '0;
      len_q        <= '0;
      disp_data_q  <= '0;
      disp_blank_q <= '1;
      wrap_q       <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      // Display follows the registered state one cycle later.
      if (state_q == IDLE) begin
        disp_data_q  <= '0;
        disp_blank_q <= '1;
      end else begin
        disp_data_q  <= win_data;
        disp_blank_q <= win_blank;
      end

      if (stop) begin
        state_q <= IDLE;
        pos_q   <= '0;
        cnt_q   <= '0;
      end else if (load_valid && load_ready) begin
        msg_q   <= load_data;
        len_q   <= len_clamp;
        pos_q   <= '0;
        cnt_q   <= '0;
        if (load_len == '0) state_q <= IDLE;
        else if (pause)     state_q <= PAUSED;
        else                state_q <= RUN;
      end else begin
        case (state_q)
          RUN: begin
            if (pause) begin
              state_q <= PAUSED;
            end else begin
              cnt_q  <= cnt_d;
              pos_q  <= pos_d;
              wrap_q <= wrap_d;
            end
          end
          PAUSED: begin
            if (!pause) begin
              state_q <= RUN;
              cnt_q   <= cnt_d;
              pos_q   <= pos_d;
              wrap_q  <= wrap_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign load_ready = (state_q != RUN);
  assign busy       = (state_q != IDLE);
  assign disp_data  = disp_data_q;
  assign disp_blank = disp_blank_q;
  assign wrap_pulse = wrap_q;

endmodule
